// File: rtl/alu_pkg.sv
// Shared types for the ALU arbiter: opcodes, flag bundle, FSM states and FP latency.
package alu_pkg;

  typedef enum logic [4:0] {
    ALU_ADD  = 5'h00,
    ALU_SUB  = 5'h01,
    ALU_AND  = 5'h02,
    ALU_OR   = 5'h03,
    ALU_XOR  = 5'h04,
    ALU_SLL  = 5'h05,
    ALU_SRL  = 5'h06,
    ALU_SRA  = 5'h07,
    ALU_SLT  = 5'h08,
    ALU_FADD = 5'h14,
    ALU_FSUB = 5'h15,
    ALU_FMUL = 5'h16,
    ALU_FDIV = 5'h17
  } alu_op_e;

  typedef struct packed {
    logic negative;
    logic carry_out;
    logic overflow;
    logic zero;
  } alu_flags_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_e;

  localparam int unsigned FP_LATENCY = 2;

  // FP ops occupy the 5'b101xx opcode group.
  function automatic logic is_fp_op(input logic [4:0] op);
    return op[4:2] == 3'b101;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// One-hot round-robin grant; requester 'ptr' has highest priority, then ptr+1, ...
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);
  localparam int unsigned IDW = $clog2(NUM_REQ);

  logic [IDW-1:0] idx;
  logic           found;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    idx      = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = IDW'((32'(ptr) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = idx;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between NUM_REQ requesters.
// Optional per-requester grant counters are built when ALU_ARB_STATS_EN is defined.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned OP_WIDTH   = 5,
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*OP_WIDTH-1:0]     req_op,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_b,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]      rsp_id,
  output logic [DATA_WIDTH-1:0]           rsp_result,
  output logic [3:0]                      rsp_flags,
  output logic                            alu_en,
  output logic [OP_WIDTH-1:0]             alu_op,
  output logic [DATA_WIDTH-1:0]           alu_operand_a,
  output logic [DATA_WIDTH-1:0]           alu_operand_b,
  input  logic [DATA_WIDTH-1:0]           alu_result,
  input  logic [DATA_WIDTH-1:0]           alu_fp_result,
  input  logic                            alu_zero,
  input  logic                            alu_overflow,
  input  logic                            alu_carry_out,
  input  logic                            alu_negative,
  output logic                            busy,
  output logic [NUM_REQ*CNT_WIDTH-1:0]    grant_cnt
);
  localparam int unsigned IDW   = $clog2(NUM_REQ);
  localparam int unsigned LAT_W = $clog2(FP_LATENCY);

  arb_state_e            state_q, state_d;
  logic [LAT_W-1:0]      issue_cnt_q, issue_cnt_d;
  logic [OP_WIDTH-1:0]   op_q;
  logic [DATA_WIDTH-1:0] a_q, b_q;
  logic [IDW-1:0]        id_q, ptr_q;
  logic [NUM_REQ-1:0]    grant;
  logic [IDW-1:0]        grant_id;
  logic                  accept;
  logic                  op_fp;
  logic                  issue_last;
  alu_flags_t            flags;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req      (req_valid),
    .ptr      (ptr_q),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign op_fp      = is_fp_op(5'(op_q));
  assign issue_last = !op_fp || (issue_cnt_q == LAT_W'(FP_LATENCY - 1));

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    accept      = 1'b0;
    case (state_q)
      IDLE: begin
        if (|grant) begin
          accept      = 1'b1;
          issue_cnt_d = '0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (issue_last) state_d = RESP;
        else            issue_cnt_d = issue_cnt_q + 1'b1;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register and request latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      issue_cnt_q <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= '0;
      ptr_q       <= '0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      if (accept) begin
        op_q  <= req_op[32'(grant_id)*OP_WIDTH +: OP_WIDTH];
        a_q   <= req_a[32'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
        b_q   <= req_b[32'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
        id_q  <= grant_id;
        ptr_q <= (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
      end
    end
  end

  assign req_ready     = (state_q == IDLE) ? grant : '0;
  assign alu_en        = (state_q == ISSUE);
  assign rsp_valid     = (state_q == RESP);
  assign busy          = (state_q != IDLE);
  assign alu_op        = op_q;
  assign alu_operand_a = a_q;
  assign alu_operand_b = b_q;
  assign rsp_id        = id_q;

  // ALU holds its registers while alu_en is low, so the pass-through payload stays stable.
  assign flags = '{negative: alu_negative, carry_out: alu_carry_out,
                   overflow: alu_overflow, zero: alu_zero};
  assign rsp_flags  = flags;
  assign rsp_result = op_fp ? alu_fp_result : alu_result;

`ifdef ALU_ARB_STATS_EN
  logic [NUM_REQ-1:0][CNT_WIDTH-1:0] cnt_q;

  // Saturating grant counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (accept && grant[i] && (cnt_q[i] != '1)) cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end

  assign grant_cnt = cnt_q;
`else
  assign grant_cnt = '0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a small registered ALU model.
module tb_alu_arbiter;
  localparam int unsigned DW = 32;
  localparam int unsigned OW = 5;
  localparam int unsigned NR = 4;
  localparam int unsigned CW = 16;
  localparam logic [4:0] OP_ADD   = 5'h00;
  localparam logic [4:0] OP_SUB   = 5'h01;
  localparam logic [4:0] OP_FADD  = 5'h14;
  localparam logic [4:0] OP_UNDEF = 5'h1F;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NR-1:0]    req_valid = '0;
  logic [NR-1:0]    req_ready;
  logic [NR*OW-1:0] req_op = '0;
  logic [NR*DW-1:0] req_a = '0;
  logic [NR*DW-1:0] req_b = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b1;
  logic [1:0]       rsp_id;
  logic [DW-1:0]    rsp_result;
  logic [3:0]       rsp_flags;
  logic             alu_en;
  logic [OW-1:0]    alu_op;
  logic [DW-1:0]    alu_operand_a, alu_operand_b;
  logic [DW-1:0]    alu_result = '0;
  logic [DW-1:0]    alu_fp_result = '0;
  logic             alu_zero = 1'b0, alu_overflow = 1'b0, alu_carry_out = 1'b0, alu_negative = 1'b0;
  logic             busy;
  logic [NR*CW-1:0] grant_cnt;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_WIDTH(DW), .OP_WIDTH(OW), .NUM_REQ(NR), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .alu_en(alu_en), .alu_op(alu_op), .alu_operand_a(alu_operand_a),
    .alu_operand_b(alu_operand_b), .alu_result(alu_result), .alu_fp_result(alu_fp_result),
    .alu_zero(alu_zero), .alu_overflow(alu_overflow), .alu_carry_out(alu_carry_out),
    .alu_negative(alu_negative), .busy(busy), .grant_cnt(grant_cnt)
  );

  // Registered ALU model: updates only while alu_en is high.
  logic [DW:0]   add_full, sub_full;
  logic [DW-1:0] m_res;
  logic          m_c, m_v;
  assign add_full = {1'b0, alu_operand_a} + {1'b0, alu_operand_b};
  assign sub_full = {1'b0, alu_operand_a} + {1'b0, ~alu_operand_b} + 33'd1;

  always_comb begin
    m_res = alu_operand_a ^ alu_operand_b;
    m_c   = 1'b0;
    m_v   = 1'b0;
    if (alu_op == OP_ADD) begin
      m_res = add_full[DW-1:0];
      m_c   = add_full[DW];
      m_v   = (alu_operand_a[DW-1] == alu_operand_b[DW-1]) && (m_res[DW-1] != alu_operand_a[DW-1]);
    end else if (alu_op == OP_SUB) begin
      m_res = sub_full[DW-1:0];
      m_c   = sub_full[DW];
      m_v   = (alu_operand_a[DW-1] != alu_operand_b[DW-1]) && (m_res[DW-1] != alu_operand_a[DW-1]);
    end
  end

  always @(posedge clk) begin
    if (alu_en) begin
      alu_result    <= m_res;
      alu_carry_out <= m_c;
      alu_overflow  <= m_v;
      alu_zero      <= (m_res == '0);
      alu_negative  <= m_res[DW-1];
      alu_fp_result <= (alu_op == OP_FADD) ? 32'h4000_0000 : 32'h7FC0_0000;
    end
  end

  task automatic set_req(input int unsigned i, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    req_op[i*OW +: OW] = op;
    req_a[i*DW +: DW]  = a;
    req_b[i*DW +: DW]  = b;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++; if (alu_en !== 1'b0) begin n_fail++; $display("FAIL reset_alu_en: got %b expected 0", alu_en); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL reset_rsp_id: got %0d expected 0", rsp_id); end
    n_checks++; if (alu_op !== 5'd0) begin n_fail++; $display("FAIL reset_alu_op: got %h expected 0", alu_op); end
    n_checks++; if (alu_operand_a !== 32'd0) begin n_fail++; $display("FAIL reset_operand_a: got %h expected 0", alu_operand_a); end
    n_checks++; if (grant_cnt !== '0) begin n_fail++; $display("FAIL reset_grant_cnt: got %h expected 0", grant_cnt); end
    rst_n = 1'b1;
  endtask

  task automatic test_int_sub();
    @(negedge clk);
    set_req(0, OP_SUB, 32'd9, 32'd9); req_valid = 4'b0001; rsp_ready = 1'b1; #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL sub_ready: got %b expected 0001", req_ready); end
    @(negedge clk);
    req_valid = 4'b0000;
    n_checks++; if (alu_en !== 1'b1) begin n_fail++; $display("FAIL sub_alu_en: got %b expected 1", alu_en); end
    n_checks++; if (alu_op !== OP_SUB) begin n_fail++; $display("FAIL sub_alu_op: got %h expected %h", alu_op, OP_SUB); end
    n_checks++; if (alu_operand_b !== 32'd9) begin n_fail++; $display("FAIL sub_operand_b: got %0d expected 9", alu_operand_b); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL sub_early_rsp: got %b expected 0", rsp_valid); end
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL sub_rsp_valid: got %b expected 1", rsp_valid); end
    n_checks++; if (rsp_result !== 32'd0) begin n_fail++; $display("FAIL sub_result: got %h expected 0", rsp_result); end
    n_checks++; if (rsp_flags !== 4'b0101) begin n_fail++; $display("FAIL sub_flags: got %b expected 0101", rsp_flags); end
    n_checks++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL sub_id: got %0d expected 0", rsp_id); end
    n_checks++; if (alu_en !== 1'b0) begin n_fail++; $display("FAIL sub_resp_alu_en: got %b expected 0", alu_en); end
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL sub_idle: got busy %b expected 0", busy); end
  endtask

  task automatic test_fp_add();
    @(negedge clk);
    set_req(2, OP_FADD, 32'h3F80_0000, 32'h3F80_0000); req_valid = 4'b0100; #1;
    n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL fp_ready: got %b expected 0100", req_ready); end
    @(negedge clk);
    req_valid = 4'b0000;
    n_checks++; if (alu_en !== 1'b1) begin n_fail++; $display("FAIL fp_alu_en_c1: got %b expected 1", alu_en); end
    @(negedge clk);
    n_checks++; if (alu_en !== 1'b1) begin n_fail++; $display("FAIL fp_alu_en_c2: got %b expected 1", alu_en); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL fp_early_rsp: got %b expected 0", rsp_valid); end
    n_checks++; if (alu_op !== OP_FADD) begin n_fail++; $display("FAIL fp_alu_op: got %h expected %h", alu_op, OP_FADD); end
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL fp_rsp_valid: got %b expected 1", rsp_valid); end
    n_checks++; if (alu_en !== 1'b0) begin n_fail++; $display("FAIL fp_alu_en_c3: got %b expected 0", alu_en); end
    n_checks++; if (rsp_result !== 32'h4000_0000) begin n_fail++; $display("FAIL fp_result: got %h expected 40000000", rsp_result); end
    n_checks++; if (rsp_id !== 2'd2) begin n_fail++; $display("FAIL fp_id: got %0d expected 2", rsp_id); end
    @(negedge clk);
  endtask

  task automatic test_undefined_op();
    @(negedge clk);
    set_req(1, OP_UNDEF, 32'h0000_00F0, 32'h0000_000F); req_valid = 4'b0010; #1;
    n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL undef_ready: got %b expected 0010", req_ready); end
    @(negedge clk);
    req_valid = 4'b0000;
    n_checks++; if (alu_op !== OP_UNDEF) begin n_fail++; $display("FAIL undef_alu_op: got %h expected 1f", alu_op); end
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL undef_latency: got %b expected 1", rsp_valid); end
    n_checks++; if (rsp_result !== 32'h0000_00FF) begin n_fail++; $display("FAIL undef_result: got %h expected ff", rsp_result); end
    n_checks++; if (rsp_id !== 2'd1) begin n_fail++; $display("FAIL undef_id: got %0d expected 1", rsp_id); end
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    int got;
    int order[6];
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, OP_ADD, 32'(i), 32'd1);
    req_valid = 4'b1111; rsp_ready = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      #1;
      if (req_ready != 4'b0000) begin
        n_checks++; if (!$onehot(req_ready)) begin n_fail++; $display("FAIL rr_onehot: got %b expected one-hot", req_ready); end
        for (int b = 0; b < 4; b++) if (req_ready[b]) order[got] = b;
        got++;
      end
      @(negedge clk);
    end
    req_valid = 4'b0000;
    n_checks++; if (got !== 6) begin n_fail++; $display("FAIL rr_timeout: got %0d grants expected 6", got); end
    for (int k = 0; k < 6; k++) begin
      n_checks++; if (order[k] !== k % 4) begin n_fail++; $display("FAIL rr_order_%0d: got %0d expected %0d", k, order[k], k % 4); end
    end
    for (int c = 0; c < 10 && busy; c++) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rr_drain: got busy %b expected 0", busy); end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    set_req(0, OP_ADD, 32'd5, 32'd7); set_req(1, OP_ADD, 32'd1, 32'd1);
    req_valid = 4'b0001; rsp_ready = 1'b0; #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL bp_ready: got %b expected 0001", req_ready); end
    @(negedge clk);
    req_valid = 4'b0011;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_%0d: got %b expected 1", k, rsp_valid); end
      n_checks++; if (rsp_result !== 32'd12) begin n_fail++; $display("FAIL bp_result_%0d: got %0d expected 12", k, rsp_result); end
      n_checks++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL bp_id_%0d: got %0d expected 0", k, rsp_id); end
      n_checks++; if (rsp_flags !== 4'b0000) begin n_fail++; $display("FAIL bp_flags_%0d: got %b expected 0000", k, rsp_flags); end
      n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_req_ready_%0d: got %b expected 0000", k, req_ready); end
      if (k < 4) @(negedge clk);
    end
    rsp_ready = 1'b1; #1;
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_release_ready: got %b expected 0000", req_ready); end
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_exit_valid: got %b expected 0", rsp_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_exit_busy: got %b expected 0", busy); end
    n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_next_grant: got %b expected 0010", req_ready); end
    req_valid = 4'b0000;
  endtask

  task automatic test_reset_mid_issue();
    @(negedge clk);
    set_req(0, OP_FADD, 32'h3F80_0000, 32'h3F80_0000); req_valid = 4'b0001; rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = 4'b0000;
    n_checks++; if (alu_en !== 1'b1) begin n_fail++; $display("FAIL mr_issue: got %b expected 1", alu_en); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (alu_en !== 1'b0) begin n_fail++; $display("FAIL mr_async_alu_en: got %b expected 0", alu_en); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mr_async_rsp: got %b expected 0", rsp_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mr_async_busy: got %b expected 0", busy); end
    @(negedge clk);
    set_req(1, OP_ADD, 32'd3, 32'd4); req_valid = 4'b0010; rst_n = 1'b1; #1;
    n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL mr_grant: got %b expected 0010", req_ready); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mr_stale_c0: got %b expected 0", rsp_valid); end
    @(negedge clk);
    req_valid = 4'b0000;
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mr_stale_c1: got %b expected 0", rsp_valid); end
    n_checks++; if (alu_operand_a !== 32'd3) begin n_fail++; $display("FAIL mr_operand_a: got %0d expected 3", alu_operand_a); end
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL mr_rsp_valid: got %b expected 1", rsp_valid); end
    n_checks++; if (rsp_id !== 2'd1) begin n_fail++; $display("FAIL mr_rsp_id: got %0d expected 1", rsp_id); end
    n_checks++; if (rsp_result !== 32'd7) begin n_fail++; $display("FAIL mr_result: got %0d expected 7", rsp_result); end
  endtask

  task automatic test_stats();
    logic [CW-1:0] exp3, exp1;
`ifdef ALU_ARB_STATS_EN
    exp3 = 16'd3; exp1 = 16'd1;
`else
    exp3 = 16'd0; exp1 = 16'd0;
`endif
    for (int g = 0; g < 3; g++) begin
      @(negedge clk);
      set_req(3, OP_ADD, 32'(g), 32'd1); req_valid = 4'b1000;
      @(negedge clk);
      req_valid = 4'b0000;
      @(negedge clk);
    end
    @(negedge clk);
    n_checks++; if (grant_cnt[3*CW +: CW] !== exp3) begin n_fail++; $display("FAIL stats_req3: got %0d expected %0d", grant_cnt[3*CW +: CW], exp3); end
    n_checks++; if (grant_cnt[1*CW +: CW] !== exp1) begin n_fail++; $display("FAIL stats_req1: got %0d expected %0d", grant_cnt[1*CW +: CW], exp1); end
    n_checks++; if (grant_cnt[0 +: CW] !== 16'd0) begin n_fail++; $display("FAIL stats_req0: got %0d expected 0", grant_cnt[0 +: CW]); end
  endtask

  initial begin
    test_reset();
    test_int_sub();
    test_fp_add();
    test_undefined_op();
    test_round_robin();
    test_backpressure();
    test_reset_mid_issue();
    test_stats();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
